intr_ctrl: RTL and testbench
============================

# intr_ctrl

Machine-mode interrupt controller for the 5-stage pipeline; the requesting side of the hazard unit's interrupt handshake. Holds the interrupt CSRs (mstatus.MIE/MPIE, mie, mtvec, mepc, mcause) and arbitrates external and timer sources. It drives `interrupt_req` into the hazard unit, consumes `interrupt_taken` and `mret_taken` from the hazard unit, and supplies the trap-entry PC and the return PC to the fetch-PC mux.

## Interface
- `XLEN`, 32, data/PC width
- `MTVEC_RESET`, 32'h0000_0100, reset value of mtvec (direct mode only)

Ports:
- `clk` in 1: single clock, all state on the rising edge
- `rst` in 1: reset; synchronous, active-high
- `ext_irq` in 1: external interrupt, level-sensitive, already synchronous to `clk`
- `interrupt_taken` in 1: from the hazard unit; the pipeline is flushed this cycle
- `mret_taken` in 1: from the hazard unit; MRET retires in WB this cycle
- `epc_in` in XLEN: PC to resume at; sampled when `interrupt_taken`=1
- `csr_we` in 1: CSR write strobe (WB stage)
- `csr_addr` in 12: CSR address for read and write
- `csr_wdata` in XLEN: CSR write data
- `csr_rdata` out XLEN: combinational read of `csr_addr`; unmapped addresses return 0
- `interrupt_req` out 1: registered request to the hazard unit
- `trap_pc` out XLEN: mtvec & ~3
- `mret_pc` out XLEN: mepc

## Operation
- Pending bits:
  - MEIP = `ext_irq`.
  - MTIP = timer compare; MTIP is 0 when the timer is compiled out.
- Enable condition: `fire` = MIE & ((MEIP & mie[11]) | (MTIP & mie[7])).
- Priority: external over timer.
  - mcause = 32'h8000_000B for external, 32'h8000_0007 for timer.
  - The cause is latched on entry to REQ.
- FSM states:
  - IDLE:
    - `fire` → REQ; `interrupt_req` is set to 1 on the same edge.
  - REQ:
    - `interrupt_taken` → HANDLER. On that edge:
      - mepc ← `epc_in` & ~3
      - MPIE ← MIE, MIE ← 0
      - mcause ← latched cause
      - `interrupt_req` ← 0
    - Otherwise, if `fire`=0 (source withdrawn, or MIE/mie cleared by a CSR write) → IDLE with `interrupt_req` ← 0.
    - Otherwise stay in REQ with `interrupt_req` held at 1.
  - HANDLER:
    - `mret_taken` → IDLE; MIE ← MPIE, MPIE ← 1.
- `mret_taken` in IDLE or REQ: MIE ← MPIE and MPIE ← 1 are still applied; the FSM is otherwise unchanged.
- CSR writes:
  - Mapped: mstatus 0x300 (bits 3 and 7 only), mie 0x304 (bits 7 and 11), mtvec 0x305, mepc 0x341, mcause 0x342.
  - Writes to unmapped addresses are ignored.
- Simultaneous events:
  - `interrupt_taken` beats `csr_we` for mstatus, mepc and mcause.
  - Writes to other CSRs still apply in that cycle.
  - `interrupt_taken` and `mret_taken` together: `interrupt_taken` wins, matching the hazard unit's priority.

## Timing
- Reset values:
  - `interrupt_req`=0, state IDLE.
  - MIE=0, MPIE=0, mie=0.
  - mtvec=`MTVEC_RESET`, mepc=0, mcause=0.
  - mtime=0, mtimecmp=all ones.
- `rst` asserted mid-operation returns every register to its reset value on that edge, in any state.
- Request latency: `fire` rising at edge N gives `interrupt_req`=1 after edge N+1's setup, i.e. one cycle.
- The hazard unit returns `interrupt_taken` combinationally in the same cycle, so REQ normally lasts one cycle.
- `trap_pc` and `mret_pc` are direct register outputs, valid in the taken cycle. A CSR write becomes visible on them the next cycle.
- `csr_rdata` shows pre-write values in the write cycle.
- Once in HANDLER, no new request is raised before `mret_taken` plus one cycle.

## Configuration
- `INTR_TIMER_EN` defined:
  - 64-bit mtime increments every cycle and wraps to 0.
  - 64-bit mtimecmp is writable at 0x7C0 (low) and 0x7C1 (high).
  - mtime is readable at 0x7C2 (low) and 0x7C3 (high).
  - MTIP = (mtime >= mtimecmp), 64-bit unsigned compare.
- `INTR_TIMER_EN` undefined:
  - No timer hardware; MTIP=0.
  - 0x7C0–0x7C3 read 0 and ignore writes.
  - mie[7] is still stored.

## Structure
- Package `intr_pkg`:
  - CSR address constants.
  - mcause codes.
  - mstatus bit indices.
  - FSM state enum (IDLE, REQ, HANDLER).
- Sub-module `intr_timer`: mtime/mtimecmp registers, CSR decode for 0x7C0–0x7C3, and the MTIP compare. It is instantiated only under `INTR_TIMER_EN`.

## Test plan
- Reset then read back: `csr_rdata`(0x305)=32'h0000_0100; `interrupt_req`=0; all other CSRs read 0.
- External interrupt entry:
  - Stimulus: write mie=0x800, mstatus=0x8; raise `ext_irq`.
  - `interrupt_req`=1 one cycle later.
  - Pulse `interrupt_taken` with `epc_in`=0x1234: mepc=0x1234, mcause=0x8000000B, mstatus=0x80, `interrupt_req`=0.
- MRET then re-entry:
  - Stimulus: in HANDLER with `ext_irq` held high, pulse `mret_taken`.
  - mstatus=0x88; `interrupt_req` rises one cycle after that.
- Withdrawal: raise `ext_irq` for one cycle, never assert `interrupt_taken` → `interrupt_req` high for exactly one cycle, then 0; state back to IDLE.
- Priority (`INTR_TIMER_EN`):
  - Stimulus: mtimecmp=5, mie=0x880, MIE=1, `ext_irq`=1 from cycle 3.
  - Taken cycle latches mcause=0x8000000B.
  - With `ext_irq`=0, mcause=0x80000007.
- Collision: `interrupt_taken` with `csr_we` to mepc=0xDEAD in the same cycle → mepc=`epc_in`; a concurrent mtvec write is applied.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the machine-mode interrupt controller: CSR map,
// mcause codes, status bit positions and the request FSM encoding.
package intr_pkg;

  localparam logic [11:0] CSR_MSTATUS     = 12'h300;
  localparam logic [11:0] CSR_MIE         = 12'h304;
  localparam logic [11:0] CSR_MTVEC       = 12'h305;
  localparam logic [11:0] CSR_MEPC        = 12'h341;
  localparam logic [11:0] CSR_MCAUSE      = 12'h342;
  localparam logic [11:0] CSR_MTIMECMP_LO = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMP_HI = 12'h7C1;
  localparam logic [11:0] CSR_MTIME_LO    = 12'h7C2;
  localparam logic [11:0] CSR_MTIME_HI    = 12'h7C3;

  localparam logic [31:0] MCAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TMR = 32'h8000_0007;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } intr_state_e;

  // The four timer CSRs occupy one aligned block of four addresses.
  function automatic logic is_timer_addr(input logic [11:0] addr);
    return addr[11:2] == CSR_MTIMECMP_LO[11:2];
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Pipeline-facing bundle of the interrupt controller: hazard-unit handshake,
// redirect PCs and the WB-stage CSR port.
interface intr_ctrl_if #(
  parameter int XLEN = 32
);
  logic            interrupt_req;
  logic            interrupt_taken;
  logic            mret_taken;
  logic [XLEN-1:0] epc_in;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] mret_pc;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport master (
    output interrupt_taken, mret_taken, epc_in, csr_we, csr_addr, csr_wdata,
    input  interrupt_req, trap_pc, mret_pc, csr_rdata
  );

  modport slave (
    input  interrupt_taken, mret_taken, epc_in, csr_we, csr_addr, csr_wdata,
    output interrupt_req, trap_pc, mret_pc, csr_rdata
  );
endinterface

// File: rtl/intr_timer.sv
// 64-bit free-running mtime with a writable mtimecmp; raises MTIP while
// mtime >= mtimecmp. Instantiated only when INTR_TIMER_EN is defined.
module intr_timer
  import intr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] rdata,
  output logic        mtip
);

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;

  // NOTE: reset here is synchronous -- it is just the highest-priority branch
  // inside the clocked block, so it only takes effect on a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (csr_we && csr_addr == CSR_MTIMECMP_LO) mtimecmp_q[31:0]  <= csr_wdata;
      if (csr_we && csr_addr == CSR_MTIMECMP_HI) mtimecmp_q[63:32] <= csr_wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (csr_addr)
      CSR_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      CSR_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      CSR_MTIME_LO:    rdata = mtime_q[31:0];
      CSR_MTIME_HI:    rdata = mtime_q[63:32];
      default:         rdata = '0;
    endcase
  end

  assign mtip = mtime_q >= mtimecmp_q;

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: CSRs, source arbitration and the
// IDLE/REQ/HANDLER handshake with the hazard unit. Timer: `define INTR_TIMER_EN.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  intr_ctrl_if.slave  bus
);

  intr_state_e     state_q, state_d;
  logic            req_q, req_d;
  logic            mie_q, mpie_q;
  logic            meie_q, mtie_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, cause_lat_q;
  logic            mtip;
  logic [31:0]     timer_rdata;

`ifdef INTR_TIMER_EN
  intr_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (bus.csr_we),
    .csr_addr  (bus.csr_addr),
    .csr_wdata (bus.csr_wdata[31:0]),
    .rdata     (timer_rdata),
    .mtip      (mtip)
  );
`else
  assign mtip        = 1'b0;
  assign timer_rdata = '0;
`endif

  logic meip_en, mtip_en, fire, take, mret_apply;
  assign meip_en    = ext_irq & meie_q;
  assign mtip_en    = mtip & mtie_q;
  assign fire       = mie_q & (meip_en | mtip_en);
  assign take       = (state_q == REQ) & bus.interrupt_taken;
  assign mret_apply = bus.mret_taken & ~take;

  // Trap entry owns mstatus/mepc/mcause in the taken cycle; other CSRs still write.
  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
  assign wr_mstatus = bus.csr_we & (bus.csr_addr == CSR_MSTATUS) & ~take;
  assign wr_mie     = bus.csr_we & (bus.csr_addr == CSR_MIE);
  assign wr_mtvec   = bus.csr_we & (bus.csr_addr == CSR_MTVEC);
  assign wr_mepc    = bus.csr_we & (bus.csr_addr == CSR_MEPC) & ~take;
  assign wr_mcause  = bus.csr_we & (bus.csr_addr == CSR_MCAUSE) & ~take;

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (fire) begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: if (take) begin
        state_d = HANDLER;
        req_d   = 1'b0;
      end else if (!fire) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      HANDLER: if (bus.mret_taken) state_d = IDLE;
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignment so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      meie_q      <= 1'b0;
      mtie_q      <= 1'b0;
      mtvec_q     <= MTVEC_RESET;
      mepc_q      <= '0;
      mcause_q    <= '0;
      cause_lat_q <= '0;
    end else begin
      if (state_q == IDLE && fire)
        cause_lat_q <= meip_en ? XLEN'(MCAUSE_EXT) : XLEN'(MCAUSE_TMR);

      if (take) begin
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
        mepc_q   <= bus.epc_in & ~XLEN'(3);
        mcause_q <= cause_lat_q;
      end else if (mret_apply) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
        mie_q  <= bus.csr_wdata[MSTATUS_MIE_BIT];
        mpie_q <= bus.csr_wdata[MSTATUS_MPIE_BIT];
      end

      if (wr_mie) begin
        meie_q <= bus.csr_wdata[MIE_MEIE_BIT];
        mtie_q <= bus.csr_wdata[MIE_MTIE_BIT];
      end
      if (wr_mtvec)  mtvec_q  <= bus.csr_wdata;
      if (wr_mepc)   mepc_q   <= bus.csr_wdata;
      if (wr_mcause) mcause_q <= bus.csr_wdata;
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        bus.csr_rdata[MSTATUS_MIE_BIT]  = mie_q;
        bus.csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE: begin
        bus.csr_rdata[MIE_MEIE_BIT] = meie_q;
        bus.csr_rdata[MIE_MTIE_BIT] = mtie_q;
      end
      CSR_MTVEC:  bus.csr_rdata = mtvec_q;
      CSR_MEPC:   bus.csr_rdata = mepc_q;
      CSR_MCAUSE: bus.csr_rdata = mcause_q;
      default: if (is_timer_addr(bus.csr_addr)) bus.csr_rdata = XLEN'(timer_rdata);
    endcase
  end

  assign bus.interrupt_req = req_q;
  assign bus.trap_pc       = mtvec_q & ~XLEN'(3);
  assign bus.mret_pc       = mepc_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: expectations are queued as stimulus is
// applied and retired against DUT outputs sampled 1+ time units after the edge.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_irq = 1'b0;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .ext_irq (ext_irq),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      $display("FAIL sb_underflow: got %08h expected none", got);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    check(e.tag, got, e.val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
    expect_val(tag, exp);
    bus.csr_addr = addr;
    #1;
    observe(bus.csr_rdata);
  endtask

  task automatic req_is(input string tag, input logic exp);
    expect_val(tag, {31'b0, exp});
    #1;
    observe({31'b0, bus.interrupt_req});
  endtask

  task automatic pc_is(input string tag, input logic [31:0] got, input logic [31:0] exp);
    expect_val(tag, exp);
    #1;
    observe(got);
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    tick();
    bus.csr_we    = 1'b0;
  endtask

  task automatic pulse_mret();
    bus.mret_taken = 1'b1;
    tick();
    bus.mret_taken = 1'b0;
  endtask

  task automatic take(input logic [31:0] epc);
    bus.interrupt_taken = 1'b1;
    bus.epc_in          = epc;
    tick();
    bus.interrupt_taken = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !bus.interrupt_req; i++) tick();
    req_is(tag, 1'b1);
  endtask

  initial begin
    bus.interrupt_taken = 1'b0;
    bus.mret_taken      = 1'b0;
    bus.epc_in          = '0;
    bus.csr_we          = 1'b0;
    bus.csr_addr        = '0;
    bus.csr_wdata       = '0;

    tick();
    tick();
    rst = 1'b0;

    // Reset state
    csr_rd(12'h305, "rst_mtvec", 32'h0000_0100);
    req_is("rst_req", 1'b0);
    csr_rd(12'h300, "rst_mstatus", 32'h0);
    csr_rd(12'h304, "rst_mie", 32'h0);
    csr_rd(12'h341, "rst_mepc", 32'h0);
    csr_rd(12'h342, "rst_mcause", 32'h0);
    pc_is("rst_trap_pc", bus.trap_pc, 32'h0000_0100);

`ifndef INTR_TIMER_EN
    csr_wr(12'h7C1, 32'hFFFF_FFFF);
    csr_rd(12'h7C1, "notimer_7c1", 32'h0);
    csr_rd(12'h7C2, "notimer_7c2", 32'h0);
`endif
    csr_wr(12'h123, 32'h5);
    csr_rd(12'h123, "unmapped", 32'h0);

    // Write masking; mie[7] stored, but no timer source fires
    csr_wr(12'h304, 32'hFFFF_FFFF);
    csr_rd(12'h304, "mie_mask", 32'h0000_0880);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_rd(12'h300, "mstatus_mask", 32'h0000_0088);
    tick();
    tick();
    req_is("no_spurious", 1'b0);
    csr_wr(12'h300, 32'h0);
    csr_wr(12'h304, 32'h800);
    csr_wr(12'h300, 32'h8);
    csr_rd(12'h300, "mstatus_en", 32'h0000_0008);

    // External entry with one-cycle request latency
    ext_irq = 1'b1;
    req_is("req_pre", 1'b0);
    tick();
    req_is("req_lat", 1'b1);
    pc_is("trap_pc_taken", bus.trap_pc, 32'h0000_0100);
    take(32'h0000_1235);
    csr_rd(12'h341, "ext_mepc", 32'h0000_1234);
    csr_rd(12'h342, "ext_mcause", 32'h8000_000B);
    csr_rd(12'h300, "ext_mstatus", 32'h0000_0080);
    req_is("ext_req_clr", 1'b0);
    pc_is("ext_mret_pc", bus.mret_pc, 32'h0000_1234);
    tick();
    req_is("handler_hold", 1'b0);

    // MRET then re-entry one cycle later
    pulse_mret();
    csr_rd(12'h300, "mret_mstatus", 32'h0000_0088);
    req_is("mret_req0", 1'b0);
    tick();
    req_is("reentry_req", 1'b1);

    // Taken beats a same-cycle mepc write and a same-cycle mret
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'h341;
    bus.csr_wdata = 32'h0000_DEAD;
    bus.mret_taken = 1'b1;
    take(32'h0000_0040);
    bus.csr_we     = 1'b0;
    bus.mret_taken = 1'b0;
    csr_rd(12'h341, "coll_mepc", 32'h0000_0040);
    csr_rd(12'h300, "coll_mstatus", 32'h0000_0080);

    // Concurrent mtvec write still applies on a taken cycle
    pulse_mret();
    tick();
    req_is("coll2_req", 1'b1);
    bus.csr_we    = 1'b1;
    bus.csr_addr  = 12'h305;
    bus.csr_wdata = 32'h0000_0203;
    take(32'h0000_0080);
    bus.csr_we = 1'b0;
    csr_rd(12'h305, "coll_mtvec", 32'h0000_0203);
    pc_is("coll_trap_pc", bus.trap_pc, 32'h0000_0200);
    csr_rd(12'h341, "coll2_mepc", 32'h0000_0080);
    ext_irq = 1'b0;
    pulse_mret();

    // Withdrawal: one-cycle source, never taken
    ext_irq = 1'b1;
    tick();
    ext_irq = 1'b0;
    req_is("wd_req", 1'b1);
    tick();
    req_is("wd_drop", 1'b0);
    tick();
    req_is("wd_idle", 1'b0);
    ext_irq = 1'b1;
    tick();
    req_is("wd_reentry", 1'b1);
    ext_irq = 1'b0;
    tick();
    req_is("wd_drop2", 1'b0);

`ifdef INTR_TIMER_EN
    // External beats timer when both pend
    csr_wr(12'h300, 32'h0);
    csr_wr(12'h304, 32'h880);
    ext_irq = 1'b1;
    csr_wr(12'h7C1, 32'h0);
    csr_wr(12'h7C0, 32'h5);
    csr_wr(12'h300, 32'h8);
    wait_req("prio_req_ext");
    take(32'h0000_0300);
    csr_rd(12'h342, "prio_mcause_ext", 32'h8000_000B);
    ext_irq = 1'b0;
    pulse_mret();
    wait_req("prio_req_tmr");
    take(32'h0000_0304);
    csr_rd(12'h342, "prio_mcause_tmr", 32'h8000_0007);
    csr_rd(12'h7C3, "mtime_hi", 32'h0);
    csr_wr(12'h304, 32'h0);
    pulse_mret();
`endif

    // Mid-operation reset from REQ
    ext_irq = 1'b1;
    tick();
    req_is("pre_rst_req", 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ext_irq = 1'b0;
    req_is("mid_rst_req", 1'b0);
    csr_rd(12'h305, "mid_rst_mtvec", 32'h0000_0100);
    csr_rd(12'h300, "mid_rst_mstatus", 32'h0);

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
